alu_op_sequencer: RTL and testbench
===================================

// Module: alu_op_sequencer
// PURPOSE
//  Request/response front end for the shared 32-bit ALU (alu: a, b, f[2:0] -> y, zero).
//  Accepts one operation at a time over a valid/ready handshake and drives the ALU.
//  Executes single-pass ops (AND/OR/ADD/SUB/SLT) and a multi-cycle shift-add MUL
//  (low 32 product bits) that reuses the ALU adder every cycle.
//  Sits between the issue logic and the combinational ALU instance.
// PARAMETERS
//  MUL_EARLY_EXIT  1   1: MUL ends when the remaining multiplier is 0; 0: always 32 iterations
// PORTS
//  clk          in   1   rising-edge clock
//  reset        in   1   asynchronous, active-high reset
//  req_valid    in   1   request present
//  req_ready    out  1   sequencer can accept (high only in IDLE)
//  req_op       in   3   000 AND, 001 OR, 010 ADD, 011 SUB, 100 SLT, 101 MUL, 11x illegal
//  req_a        in   32  operand A (MUL: multiplicand)
//  req_b        in   32  operand B (MUL: multiplier)
//  rsp_valid    out  1   response present; held until rsp_ready
//  rsp_ready    in   1   consumer accepts response
//  rsp_result   out  32  result
//  rsp_zero     out  1   result == 0
//  rsp_err      out  1   illegal opcode
//  busy         out  1   state != IDLE
//  alu_a        out  32  to ALU a
//  alu_b        out  32  to ALU b
//  alu_f        out  3   to ALU f
//  alu_y        in   32  from ALU y
//  alu_zero     in   1   from ALU zero
// BEHAVIOUR
//  - Reset (async): state IDLE; rsp_valid/rsp_err/busy 0, rsp_result 0, rsp_zero 0,
//    req_ready 1; all internal regs 0. Reset mid-operation abandons it; nothing emitted.
//  - States: IDLE, EXEC, MUL, RESP. One op in flight; no request accepted outside IDLE.
//  - IDLE: req_ready=1. Handshake (req_valid & req_ready) latches op/a/b. op 000-100 -> EXEC;
//    101 -> MUL with acc=0, mc=a, mp=b, cnt=0; 11x -> RESP with result 0, zero 1, err 1.
//  - ALU f mapping: AND 000, OR 001, ADD 010, SUB 110, SLT 111 (signed, via sign of a-b).
//  - EXEC (1 cycle): drive alu_a=a, alu_b=b, alu_f=mapped; capture alu_y -> rsp_result,
//    alu_zero -> rsp_zero, err=0; -> RESP. Handshake at edge k => rsp_valid from edge k+2.
//  - MUL, each cycle: if (MUL_EARLY_EXIT & mp==0) | cnt==32 -> RESP, rsp_result=acc,
//    rsp_zero=(acc==0) computed locally. Else alu_a=acc, alu_b=mc, alu_f=010;
//    acc<=alu_y if mp[0]; mc<=mc<<1; mp<=mp>>1; cnt<=cnt+1 (6-bit).
//    Product is modulo 2^32; ALU carry-out ignored. Cycles in MUL = iterations+1, where
//    iterations = index of highest set bit of b + 1 (early exit) or 32; b=0 -> 1 cycle.
//  - Outside EXEC/MUL-iterate, alu_a=alu_b=0, alu_f=000.
//  - RESP: rsp_valid=1; result/zero/err stable while rsp_ready=0. On rsp_ready -> IDLE;
//    new request acceptable one cycle later (no same-cycle rsp/req overlap).
//  - req_* ignored while not in IDLE; req_valid may drop before acceptance.
// TESTING
//  1 ADD 7+5, rsp_ready=1 -> rsp_result 12, rsp_zero 0, rsp_valid 2 cycles after handshake.
//  2 SUB 5-5 -> result 0, zero 1; SLT a=0xFFFFFFFF b=1 -> result 1; SLT a=1 b=0xFFFFFFFF -> 0.
//  3 MUL 6*7 -> 42, 4 cycles in MUL (early exit); MUL 0xFFFFFFFF*2 -> 0xFFFFFFFE;
//    MUL 9*0 -> 0, zero 1, 1 MUL cycle; MUL_EARLY_EXIT=0: 6*7 -> 42 after 33 MUL cycles.
//  4 Backpressure: rsp_ready low 5 cycles -> rsp_valid and outputs stable; req_ready 0 throughout.
//  5 Illegal op 110 -> result 0, zero 1, err 1, rsp_valid one edge after handshake.
//  6 Assert reset during MUL iteration 10 -> IDLE immediately, rsp_valid 0; next ADD 1+1 -> 2.

Source files
------------

// File: rtl/alu_op_sequencer.sv
// Valid/ready front end for the shared 32-bit ALU: single-pass logic/arith ops
// plus a shift-add multiply that reuses the ALU adder once per iteration.
module alu_op_sequencer #(
   parameter bit MUL_EARLY_EXIT = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [2:0]  req_op,
   input  logic [31:0] req_a,
   input  logic [31:0] req_b,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_result,
   output logic        rsp_zero,
   output logic        rsp_err,
   output logic        busy,
   output logic [31:0] alu_a,
   output logic [31:0] alu_b,
   output logic [2:0]  alu_f,
   input  logic [31:0] alu_y,
   input  logic        alu_zero
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_MUL  = 2'd2,
      S_RESP = 2'd3
   } state_t;

   state_t      state_q, state_d;
   logic [2:0]  op_q, op_d;
   logic [31:0] a_q, a_d;      // operand A; multiplicand during MUL
   logic [31:0] b_q, b_d;      // operand B; remaining multiplier during MUL
   logic [31:0] acc_q, acc_d;
   logic [5:0]  cnt_q, cnt_d;
   logic [31:0] result_q, result_d;
   logic        zero_q, zero_d;
   logic        err_q, err_d;
   logic        mul_done_s;

   function automatic logic [2:0] map_alu_f(input logic [2:0] op);
      logic [2:0] f;
      case (op)
         3'b000:  f = 3'b000;
         3'b001:  f = 3'b001;
         3'b010:  f = 3'b010;
         3'b011:  f = 3'b110;
         3'b100:  f = 3'b111;
         default: f = 3'b000;
      endcase
      return f;
   endfunction

   assign mul_done_s = (MUL_EARLY_EXIT && (b_q == 32'd0)) || (cnt_q == 6'd32);

   // Next-state, datapath update and ALU drive
   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      a_d      = a_q;
      b_d      = b_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      result_d = result_q;
      zero_d   = zero_q;
      err_d    = err_q;
      alu_a    = 32'd0;
      alu_b    = 32'd0;
      alu_f    = 3'b000;
      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               op_d  = req_op;
               a_d   = req_a;
               b_d   = req_b;
               acc_d = 32'd0;
               cnt_d = 6'd0;
               if (req_op[2:1] == 2'b11) begin
                  state_d  = S_RESP;
                  result_d = 32'd0;
                  zero_d   = 1'b1;
                  err_d    = 1'b1;
               end else if (req_op == 3'b101) begin
                  state_d = S_MUL;
               end else begin
                  state_d = S_EXEC;
               end
            end else begin
               state_d = S_IDLE;
            end
         end
         S_EXEC: begin
            alu_a    = a_q;
            alu_b    = b_q;
            alu_f    = map_alu_f(op_q);
            result_d = alu_y;
            zero_d   = alu_zero;
            err_d    = 1'b0;
            state_d  = S_RESP;
         end
         S_MUL: begin
            if (mul_done_s) begin
               result_d = acc_q;
               zero_d   = (acc_q == 32'd0);
               err_d    = 1'b0;
               state_d  = S_RESP;
            end else begin
               alu_a = acc_q;
               alu_b = a_q;
               alu_f = 3'b010;
               if (b_q[0]) begin
                  acc_d = alu_y;
               end else begin
                  acc_d = acc_q;
               end
               a_d   = {a_q[30:0], 1'b0};
               b_d   = {1'b0, b_q[31:1]};
               cnt_d = cnt_q + 6'd1;
            end
         end
         S_RESP: begin
            if (rsp_ready) begin
               state_d = S_IDLE;
            end else begin
               state_d = S_RESP;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and datapath registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= S_IDLE;
         op_q     <= 3'd0;
         a_q      <= 32'd0;
         b_q      <= 32'd0;
         acc_q    <= 32'd0;
         cnt_q    <= 6'd0;
         result_q <= 32'd0;
         zero_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         a_q      <= a_d;
         b_q      <= b_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         result_q <= result_d;
         zero_q   <= zero_d;
         err_q    <= err_d;
      end
   end

   assign req_ready  = (state_q == S_IDLE);
   assign busy       = (state_q != S_IDLE);
   assign rsp_valid  = (state_q == S_RESP);
   assign rsp_result = result_q;
   assign rsp_zero   = zero_q;
   assign rsp_err    = err_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed table-driven bench for alu_op_sequencer with a behavioural ALU model.
module tb_alu_op_sequencer;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid, req_valid2, rsp_ready;
   logic [2:0]  req_op;
   logic [31:0] req_a, req_b;

   logic        req_ready1, rsp_valid1, rsp_zero1, rsp_err1, busy1, alu_zero1;
   logic [31:0] rsp_result1, alu_a1, alu_b1, alu_y1;
   logic [2:0]  alu_f1;
   logic        req_ready2, rsp_valid2, rsp_zero2, rsp_err2, busy2, alu_zero2;
   logic [31:0] rsp_result2, alu_a2, alu_b2, alu_y2;
   logic [2:0]  alu_f2;

   int n_checks = 0;
   int n_fail   = 0;
   bit sel      = 1'b0;

   always #5 clk = ~clk;

   function automatic logic [31:0] alu_model(input logic [31:0] a, input logic [31:0] b,
                                             input logic [2:0] f);
      case (f)
         3'b000:  return a & b;
         3'b001:  return a | b;
         3'b010:  return a + b;
         3'b110:  return a - b;
         3'b111:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         default: return 32'd0;
      endcase
   endfunction

   assign alu_y1    = alu_model(alu_a1, alu_b1, alu_f1);
   assign alu_zero1 = (alu_y1 == 32'd0);
   assign alu_y2    = alu_model(alu_a2, alu_b2, alu_f2);
   assign alu_zero2 = (alu_y2 == 32'd0);

   alu_op_sequencer #(.MUL_EARLY_EXIT(1'b1)) dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready1),
      .req_op(req_op), .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid1),
      .rsp_ready(rsp_ready), .rsp_result(rsp_result1), .rsp_zero(rsp_zero1),
      .rsp_err(rsp_err1), .busy(busy1), .alu_a(alu_a1), .alu_b(alu_b1),
      .alu_f(alu_f1), .alu_y(alu_y1), .alu_zero(alu_zero1));

   alu_op_sequencer #(.MUL_EARLY_EXIT(1'b0)) dut_full (
      .clk(clk), .reset(reset), .req_valid(req_valid2), .req_ready(req_ready2),
      .req_op(req_op), .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid2),
      .rsp_ready(rsp_ready), .rsp_result(rsp_result2), .rsp_zero(rsp_zero2),
      .rsp_err(rsp_err2), .busy(busy2), .alu_a(alu_a2), .alu_b(alu_b2),
      .alu_f(alu_f2), .alu_y(alu_y2), .alu_zero(alu_zero2));

   wire        m_valid  = sel ? rsp_valid2  : rsp_valid1;
   wire        m_ready  = sel ? req_ready2  : req_ready1;
   wire        m_busy   = sel ? busy2       : busy1;
   wire [31:0] m_result = sel ? rsp_result2 : rsp_result1;
   wire        m_zero   = sel ? rsp_zero2   : rsp_zero1;
   wire        m_err    = sel ? rsp_err2    : rsp_err1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Issue one op, wait for the response, hold rsp_ready low for `hold` cycles, then retire it.
   task automatic run_op(input bit which, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input int hold,
                         output logic [31:0] res, output logic z, output logic e,
                         output int lat, output int cyc);
      @(negedge clk);
      sel       = which;
      req_op    = op;
      req_a     = a;
      req_b     = b;
      rsp_ready = 1'b0;
      if (which) req_valid2 = 1'b1;
      else       req_valid  = 1'b1;
      @(posedge clk);
      @(negedge clk);
      req_valid  = 1'b0;
      req_valid2 = 1'b0;
      lat = 1;
      cyc = 0;
      while (!m_valid && lat < 100) begin
         if (m_busy) cyc++;
         @(negedge clk);
         lat++;
      end
      if (!m_valid) chk("rsp_timeout", 32'(m_valid), 32'd1);
      res = m_result;
      z   = m_zero;
      e   = m_err;
      for (int i = 0; i < hold; i++) begin
         req_valid = 1'b1;  // ignored while busy
         req_op    = 3'b010;
         @(negedge clk);
         chk("bp_valid", 32'(m_valid), 32'd1);
         chk("bp_req_ready", 32'(m_ready), 32'd0);
         chk("bp_result", m_result, res);
         chk("bp_zero_err", {30'd0, m_zero, m_err}, {30'd0, z, e});
      end
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rsp_ready = 1'b0;
      chk("retire_valid", 32'(m_valid), 32'd0);
      chk("retire_req_ready", 32'(m_ready), 32'd1);
   endtask

   typedef struct {
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
      logic        zero;
      logic        err;
      int          cyc;   // busy cycles before rsp_valid
   } vec_t;

   vec_t vecs[14];

   initial begin
      logic [31:0] r;
      logic        z, e;
      int          lat, cyc;

      vecs[0]  = '{3'b010, 32'd7, 32'd5, 32'd12, 1'b0, 1'b0, 1};
      vecs[1]  = '{3'b011, 32'd5, 32'd5, 32'd0, 1'b1, 1'b0, 1};
      vecs[2]  = '{3'b100, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, 1'b0, 1};
      vecs[3]  = '{3'b100, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b1, 1'b0, 1};
      vecs[4]  = '{3'b011, 32'd3, 32'd5, 32'hFFFF_FFFE, 1'b0, 1'b0, 1};
      vecs[5]  = '{3'b000, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0, 1'b0, 1};
      vecs[6]  = '{3'b001, 32'h0F0F_0000, 32'h0000_00F0, 32'h0F0F_00F0, 1'b0, 1'b0, 1};
      vecs[7]  = '{3'b101, 32'd6, 32'd7, 32'd42, 1'b0, 1'b0, 4};
      vecs[8]  = '{3'b101, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE, 1'b0, 1'b0, 3};
      vecs[9]  = '{3'b101, 32'd9, 32'd0, 32'd0, 1'b1, 1'b0, 1};
      vecs[10] = '{3'b101, 32'h0001_0000, 32'h0001_0000, 32'd0, 1'b1, 1'b0, 18};
      vecs[11] = '{3'b101, 32'd3, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 33};
      vecs[12] = '{3'b110, 32'd4, 32'd4, 32'd0, 1'b1, 1'b1, 0};
      vecs[13] = '{3'b111, 32'd1, 32'd2, 32'd0, 1'b1, 1'b1, 0};

      reset = 1'b1; req_valid = 1'b0; req_valid2 = 1'b0; rsp_ready = 1'b0;
      req_op = 3'd0; req_a = 32'd0; req_b = 32'd0;
      repeat (2) @(negedge clk);
      chk("reset_rsp_valid", 32'(rsp_valid1), 32'd0);
      chk("reset_req_ready", 32'(req_ready1), 32'd1);
      chk("reset_busy", 32'(busy1), 32'd0);
      chk("reset_result", rsp_result1, 32'd0);
      chk("reset_zero_err", {30'd0, rsp_zero1, rsp_err1}, 32'd0);
      reset = 1'b0;

      for (int i = 0; i < 14; i++) begin
         run_op(1'b0, vecs[i].op, vecs[i].a, vecs[i].b, 0, r, z, e, lat, cyc);
         chk($sformatf("v%0d_result", i), r, vecs[i].res);
         chk($sformatf("v%0d_zero", i), 32'(z), 32'(vecs[i].zero));
         chk($sformatf("v%0d_err", i), 32'(e), 32'(vecs[i].err));
         chk($sformatf("v%0d_cycles", i), 32'(cyc), 32'(vecs[i].cyc));
         chk($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].cyc + 1));
      end

      // Backpressure on an ADD
      run_op(1'b0, 3'b010, 32'd100, 32'd23, 5, r, z, e, lat, cyc);
      chk("bp_add_result", r, 32'd123);

      // Full-length multiply without early exit
      run_op(1'b1, 3'b101, 32'd6, 32'd7, 0, r, z, e, lat, cyc);
      chk("full_mul_result", r, 32'd42);
      chk("full_mul_cycles", 32'(cyc), 32'd33);

      // Reset during MUL iteration 10 abandons the op
      @(negedge clk);
      sel = 1'b0; req_op = 3'b101; req_a = 32'd3; req_b = 32'h0000_FFFF; req_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      repeat (9) @(negedge clk);
      chk("pre_reset_busy", 32'(busy1), 32'd1);
      #2 reset = 1'b1;
      #1;
      chk("mid_reset_valid", 32'(rsp_valid1), 32'd0);
      chk("mid_reset_busy", 32'(busy1), 32'd0);
      chk("mid_reset_ready", 32'(req_ready1), 32'd1);
      @(negedge clk);
      reset = 1'b0;
      run_op(1'b0, 3'b010, 32'd1, 32'd1, 0, r, z, e, lat, cyc);
      chk("post_reset_add", r, 32'd2);
      chk("post_reset_zero_err", {30'd0, z, e}, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
